axi4lite_read_arbiter: RTL and testbench
========================================

# axi4lite_read_arbiter

Two-requester arbiter that shares one AXI4-Lite read port to unified memory between the core's instruction-fetch bus and data-read bus. It sits between the core and the memory/interconnect. It issues one read transaction at a time and routes the read response back only to the requester that was granted. Arbitration is round-robin by default, or data-first with a starvation guard that protects instruction fetch.

## Interface
Parameters:
- `DATA_FIRST`, default `0`. 0 selects round-robin on a tie; 1 makes the data requester win ties.
- `MAX_CONSEC`, default `4`. Used only when `DATA_FIRST=1`: the maximum number of consecutive data grants while instruction fetch is pending. Legal range 1..15.

Ports:
- `clk`  input  1  clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `inst_s`  AXI4LiteReadIF.Slave  -  instruction requester, requester 0; fields `addr`, `avalid`, `aready`, `data`, `dvalid`, `ready`.
- `data_s`  AXI4LiteReadIF.Slave  -  data requester, requester 1; same fields.
- `mem_m`  AXI4LiteReadIF.Master  -  shared downstream read port.

## Operation
- FSM states: `IDLE`, `ADDR`, `DATA`.
- Transitions out of `IDLE`:
  - If neither `avalid` is set, stay in `IDLE`.
  - Otherwise pick one requester, register its id in `gnt`, and go to `ADDR`.
- Pick rule:
  - One requester valid: grant it.
  - Both valid, `DATA_FIRST=0`: grant the requester not equal to `last_gnt`.
  - Both valid, `DATA_FIRST=1`: grant data, unless `consec == MAX_CONSEC`, in which case grant inst.
- `consec` counter (4 bits):
  - Increments on each data grant made while `inst_s.avalid=1`.
  - Clears on any inst grant.
  - Saturates at `MAX_CONSEC`.
- `ADDR` state:
  - `mem_m.avalid = gnt.avalid` and `mem_m.addr = gnt.addr`.
  - `gnt.aready = mem_m.aready`.
  - On `mem_m.avalid && mem_m.aready`: go to `DATA`, and set `last_gnt <= gnt`.
- `DATA` state:
  - `mem_m.ready = gnt.ready`.
  - `gnt.dvalid = mem_m.dvalid` and `gnt.data = mem_m.data`.
  - On `mem_m.dvalid && gnt.ready`: go to `IDLE`.
- Non-granted requester, in every state: `aready=0`, `dvalid=0`, `data=0`.
- Outside `ADDR`: `mem_m.avalid=0` and `mem_m.addr=0`.
- Outside `DATA`: `mem_m.ready=0`.
- A requester that drops `avalid` while in `ADDR` violates protocol. The arbiter does not recover from this: `mem_m.avalid` follows the requester low, and the FSM stays in `ADDR`.
- Only one transaction is ever outstanding. No address or response buffering.
- Reset (asynchronous, any state, including mid-transaction):
  - State `IDLE`, `gnt=0`, `last_gnt=1` (so inst wins the first tie), `consec=0`.
  - All outputs 0.
  - The in-flight downstream transaction is abandoned; downstream is reset by the same `rst_n`.

## Timing
- Grant is registered, with no combinational path from `avalid` to `mem_m.avalid`.
- Earliest `mem_m.avalid`: the cycle after the requester's `avalid` is seen in `IDLE`.
- Minimum transaction is 3 cycles (`IDLE`, `ADDR`, `DATA`), given zero-wait `aready` and `dvalid`.
- Back-to-back transactions from alternating requesters: one every 3 cycles.
- Combinational paths: `mem_m.aready` to `gnt.aready`, `mem_m.dvalid` to `gnt.dvalid`, `gnt.ready` to `mem_m.ready`. All are same-cycle. No path goes from any requester back to itself.
- Simultaneous events:
  - Handshake completing in `DATA` while the other requester is valid: return to `IDLE`, re-arbitrate the next cycle using the updated `last_gnt`.
  - `avalid` asserted in the same cycle `DATA` completes: seen in `IDLE` on the following cycle.
- `consec` and `last_gnt` update only on a grant or an address handshake, never during stalls.

## Structure
- Package `AXI4LiteArbPkg`:
  - `typedef enum logic [1:0] {IDLE, ADDR, DATA} ArbState`.
  - `typedef enum logic {GNT_INST=0, GNT_DATA=1} ArbGnt`.
- Sub-module `arb_picker`: combinational pick from (`req[1:0]`, `last_gnt`, `consec`, `DATA_FIRST`, `MAX_CONSEC`) to `ArbGnt`. The FSM and muxing stay in the top module.

## Test plan
- Reset, then `inst_s.avalid=1`, `addr=0x0000_0000`; memory has zero-wait and returns `0x0000_0013`:
  - `mem_m.avalid` at cycle 1, `inst_s.dvalid=1` with data `0x13` at cycle 2.
  - `data_s` sees `aready=dvalid=0` throughout.
- Both requesters valid continuously, `DATA_FIRST=0`:
  - Grant order inst, data, inst, data.
  - `mem_m.addr` alternates between `inst_s.addr=0x100` and `data_s.addr=0x2000`.
- `DATA_FIRST=1`, `MAX_CONSEC=2`, both valid continuously: grant order data, data, inst, data, data, inst.
- Backpressure:
  - `mem_m.aready` held 0 for 5 cycles: stays in `ADDR` with `addr` stable.
  - Then `mem_m.dvalid=1` with `data_s.ready=0` for 3 cycles: stays in `DATA`, and `mem_m.ready=0` until `data_s.ready=1`.
- Assert `rst_n=0` during `DATA`:
  - All outputs are 0 in the same cycle.
  - After release, both requesters valid: inst is granted first.
- Single data read of `0x8000_0004` returning `0xDEADBEEF`:
  - `data_s.data=0xDEADBEEF` only in the `dvalid` cycle.
  - `inst_s.data=0` in all cycles.

Source files
------------

// File: rtl/axi4lite_read_arbiter_pkg.sv
// Shared types for the two-requester AXI4-Lite read arbiter.
// Provides FSM state, grant id and bus widths.
package AXI4LiteArbPkg;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } ArbState;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } ArbGnt;

endpackage

// File: rtl/axi4lite_read_if.sv
// AXI4-Lite read channel bundle: addr/avalid/aready, data/dvalid/ready.
// Slave modport faces a requester, Master modport faces memory.
interface AXI4LiteReadIF;
  import AXI4LiteArbPkg::*;

  logic [AW-1:0] addr;
  logic          avalid;
  logic          aready;
  logic [DW-1:0] data;
  logic          dvalid;
  logic          ready;

  modport Slave (
    input  addr, avalid, ready,
    output aready, data, dvalid
  );

  modport Master (
    output addr, avalid, ready,
    input  aready, data, dvalid
  );

endinterface

// File: rtl/axi4lite_read_arbiter_picker.sv
// Combinational winner select from req[1:0], last_gnt and consec.
// Ports: req (bit0 inst, bit1 data), last_gnt, consec -> pick.
module arb_picker
  import AXI4LiteArbPkg::*;
#(
  parameter int DATA_FIRST = 0,
  parameter int MAX_CONSEC = 4
) (
  input  logic [1:0] req,
  input  ArbGnt      last_gnt,
  input  logic [3:0] consec,
  output ArbGnt      pick
);

  logic tie_data;

  always_comb begin
    tie_data = (DATA_FIRST != 0)
             ? (consec != 4'(MAX_CONSEC))
             : (last_gnt == GNT_INST);
    pick = GNT_INST;
    unique case (1'b1)
      (req == 2'b10): pick = GNT_DATA;
      (req == 2'b11): pick = tie_data ? GNT_DATA : GNT_INST;
      default:        pick = GNT_INST;
    endcase
  end

endmodule

// File: rtl/axi4lite_read_arbiter.sv
// Shares one AXI4-Lite read port between inst fetch and data read.
// Ports: clk, rst_n, inst_s/data_s (Slave), mem_m (Master).
module axi4lite_read_arbiter
  import AXI4LiteArbPkg::*;
#(
  parameter int DATA_FIRST = 0,
  parameter int MAX_CONSEC = 4
) (
  input logic           clk,
  input logic           rst_n,
  AXI4LiteReadIF.Slave  inst_s,
  AXI4LiteReadIF.Slave  data_s,
  AXI4LiteReadIF.Master mem_m
);

  ArbState       state, state_n;
  ArbGnt         gnt, gnt_n;
  ArbGnt         last_gnt, last_n;
  ArbGnt         pick;
  logic [3:0]    consec, consec_n;

  logic          in_addr, in_data, is_inst;
  logic          sel_avalid, sel_ready;
  logic [AW-1:0] sel_addr;

  arb_picker #(
    .DATA_FIRST (DATA_FIRST),
    .MAX_CONSEC (MAX_CONSEC)
  ) u_pick (
    .req      ({data_s.avalid, inst_s.avalid}),
    .last_gnt (last_gnt),
    .consec   (consec),
    .pick     (pick)
  );

  assign in_addr    = (state == ADDR);
  assign in_data    = (state == DATA);
  assign is_inst    = (gnt == GNT_INST);
  assign sel_avalid = is_inst ? inst_s.avalid : data_s.avalid;
  assign sel_addr   = is_inst ? inst_s.addr : data_s.addr;
  assign sel_ready  = is_inst ? inst_s.ready : data_s.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= GNT_INST;
      last_gnt <= GNT_DATA;
      consec   <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      last_gnt <= last_n;
      consec   <= consec_n;
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    last_n   = last_gnt;
    consec_n = consec;
    unique case (state)
      IDLE: begin
        if (inst_s.avalid || data_s.avalid) begin
          state_n = ADDR;
          gnt_n   = pick;
          // consec only counts data wins that made inst wait
          if (pick == GNT_INST) begin
            consec_n = '0;
          end else if (inst_s.avalid &&
                       consec != 4'(MAX_CONSEC)) begin
            consec_n = consec + 4'd1;
          end
        end
      end
      ADDR: begin
        if (sel_avalid && mem_m.aready) begin
          state_n = DATA;
          last_n  = gnt;
        end
      end
      DATA: begin
        if (mem_m.dvalid && sel_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_m.avalid  = in_addr & sel_avalid;
  assign mem_m.addr    = in_addr ? sel_addr : '0;
  assign mem_m.ready   = in_data & sel_ready;

  assign inst_s.aready = in_addr & is_inst & mem_m.aready;
  assign data_s.aready = in_addr & ~is_inst & mem_m.aready;
  assign inst_s.dvalid = in_data & is_inst & mem_m.dvalid;
  assign data_s.dvalid = in_data & ~is_inst & mem_m.dvalid;
  assign inst_s.data   = (in_data & is_inst) ? mem_m.data : '0;
  assign data_s.data   = (in_data & ~is_inst) ? mem_m.data : '0;

endmodule

// File: tb/tb_axi4lite_read_arbiter.sv
// Bench for axi4lite_read_arbiter: directed steps then random traffic
// against a transaction-level arbitration model.
module tb_axi4lite_read_arbiter;
  import AXI4LiteArbPkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  AXI4LiteReadIF i0 ();
  AXI4LiteReadIF d0 ();
  AXI4LiteReadIF m0 ();
  AXI4LiteReadIF i1 ();
  AXI4LiteReadIF d1 ();
  AXI4LiteReadIF m1 ();

  assign i1.addr   = i0.addr;
  assign i1.avalid = i0.avalid;
  assign i1.ready  = i0.ready;
  assign d1.addr   = d0.addr;
  assign d1.avalid = d0.avalid;
  assign d1.ready  = d0.ready;
  assign m1.aready = m0.aready;
  assign m1.dvalid = m0.dvalid;
  assign m1.data   = m0.data;

  axi4lite_read_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .inst_s (i0),
    .data_s (d0),
    .mem_m  (m0)
  );

  axi4lite_read_arbiter #(
    .DATA_FIRST (1),
    .MAX_CONSEC (2)
  ) dut_df (
    .clk    (clk),
    .rst_n  (rst_n),
    .inst_s (i1),
    .data_s (d1),
    .mem_m  (m1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_mav"}, m0.avalid, 1'b0);
    chk1({tag, "_mrdy"}, m0.ready, 1'b0);
    chk32({tag, "_maddr"}, m0.addr, '0);
    chk1({tag, "_iar"}, i0.aready, 1'b0);
    chk1({tag, "_idv"}, i0.dvalid, 1'b0);
    chk32({tag, "_idat"}, i0.data, '0);
    chk1({tag, "_dar"}, d0.aready, 1'b0);
    chk1({tag, "_ddv"}, d0.dvalid, 1'b0);
    chk32({tag, "_ddat"}, d0.data, '0);
  endtask

  task automatic idle_inputs();
    i0.addr = '0; i0.avalid = 1'b0; i0.ready = 1'b0;
    d0.addr = '0; d0.avalid = 1'b0; d0.ready = 1'b0;
    m0.aready = 1'b0; m0.dvalid = 1'b0; m0.data = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  logic [31:0] hs0[$];
  logic [31:0] hs1[$];
  int          cyc0[$];
  logic [31:0] rr_exp[4];
  logic [31:0] df_exp[6];

  logic        pend[2];
  logic        awaitr[2];
  logic        rdy[2];
  logic [31:0] raddr[2];
  logic        aphase, owed, m_ar, m_dv;
  logic [31:0] m_dat;
  int          owner, last, nxfer;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk_zero("rst");
    chk1("rst_df_mav", m1.avalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // single inst fetch, zero-wait memory
    i0.avalid = 1'b1; i0.addr = 32'h0; i0.ready = 1'b1;
    m0.aready = 1'b1;
    #1;
    chk1("t1_c0_mav", m0.avalid, 1'b0);
    step(); #1;
    chk1("t1_c1_mav", m0.avalid, 1'b1);
    chk32("t1_c1_addr", m0.addr, 32'h0);
    chk1("t1_c1_dar", d0.aready, 1'b0);
    step();
    i0.avalid = 1'b0; m0.aready = 1'b0;
    m0.dvalid = 1'b1; m0.data = 32'h0000_0013;
    #1;
    chk1("t1_c2_idv", i0.dvalid, 1'b1);
    chk32("t1_c2_idat", i0.data, 32'h13);
    chk1("t1_c2_mrdy", m0.ready, 1'b1);
    chk1("t1_c2_ddv", d0.dvalid, 1'b0);
    step();
    m0.dvalid = 1'b0; m0.data = '0;
    #1;
    chk1("t1_c3_idv", i0.dvalid, 1'b0);
    chk1("t1_c3_mav", m0.avalid, 1'b0);

    // both valid continuously: RR on dut, data-first on dut_df
    do_reset();
    i0.avalid = 1'b1; i0.addr = 32'h100; i0.ready = 1'b1;
    d0.avalid = 1'b1; d0.addr = 32'h2000; d0.ready = 1'b1;
    m0.aready = 1'b1; m0.dvalid = 1'b1; m0.data = 32'hCAFE;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (m0.avalid && m0.aready) begin
        hs0.push_back(m0.addr);
        cyc0.push_back(c);
      end
      if (m1.avalid && m1.aready) hs1.push_back(m1.addr);
      step();
    end
    rr_exp = '{32'h100, 32'h2000, 32'h100, 32'h2000};
    df_exp = '{32'h2000, 32'h2000, 32'h100,
               32'h2000, 32'h2000, 32'h100};
    chk1("rr_count", hs0.size() >= 4, 1'b1);
    chk1("df_count", hs1.size() >= 6, 1'b1);
    for (int i = 0; i < 4; i++)
      if (i < hs0.size()) chk32("rr_order", hs0[i], rr_exp[i]);
    for (int i = 1; i < 4; i++)
      if (i < cyc0.size())
        chk32("rr_gap", 32'(cyc0[i] - cyc0[i-1]), 32'd3);
    for (int i = 0; i < 6; i++)
      if (i < hs1.size()) chk32("df_order", hs1[i], df_exp[i]);

    // backpressure on address then on response
    do_reset();
    d0.avalid = 1'b1; d0.addr = 32'h3000; d0.ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step(); #1;
      chk1("bp_av", m0.avalid, 1'b1);
      chk32("bp_addr", m0.addr, 32'h3000);
      chk1("bp_dar", d0.aready, 1'b0);
    end
    step();
    m0.aready = 1'b1;
    #1;
    chk1("bp_hs_dar", d0.aready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      d0.avalid = 1'b0; m0.aready = 1'b0;
      m0.dvalid = 1'b1; m0.data = 32'h55AA;
      #1;
      chk1("bp_mrdy_lo", m0.ready, 1'b0);
      chk1("bp_ddv", d0.dvalid, 1'b1);
    end
    step();
    d0.ready = 1'b1;
    #1;
    chk1("bp_mrdy_hi", m0.ready, 1'b1);
    chk32("bp_ddat", d0.data, 32'h55AA);
    step(); #1;
    chk1("bp_done_ddv", d0.dvalid, 1'b0);

    // async reset while in DATA
    do_reset();
    i0.avalid = 1'b1; i0.addr = 32'h40; i0.ready = 1'b0;
    m0.aready = 1'b1;
    step();
    step();
    i0.avalid = 1'b0; m0.aready = 1'b0;
    m0.dvalid = 1'b1; m0.data = 32'h77;
    #1;
    chk1("rd_in_data", i0.dvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_zero("rd_rst");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    i0.avalid = 1'b1; i0.addr = 32'h100; i0.ready = 1'b1;
    d0.avalid = 1'b1; d0.addr = 32'h2000; d0.ready = 1'b1;
    m0.aready = 1'b1;
    step(); #1;
    chk32("rd_first_addr", m0.addr, 32'h100);
    chk1("rd_first_iar", i0.aready, 1'b1);

    // single data read with one response wait cycle
    do_reset();
    d0.addr = 32'h8000_0004; d0.ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      d0.avalid = (c < 2);
      m0.aready = (c == 1);
      m0.dvalid = (c >= 3);
      m0.data   = (c >= 3) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      chk32("dr_ddat", d0.data, (c == 3) ? 32'hDEAD_BEEF : 32'h0);
      chk1("dr_ddv", d0.dvalid, c == 3);
      chk32("dr_idat", i0.data, 32'h0);
      step();
    end

    // random traffic, round-robin instance
    do_reset();
    pend = '{1'b0, 1'b0};
    awaitr = '{1'b0, 1'b0};
    raddr = '{32'h0, 32'h0};
    aphase = 1'b0; owed = 1'b0;
    owner = 0; last = 1; nxfer = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && !awaitr[r] && $urandom_range(2) == 0) begin
          pend[r]  = 1'b1;
          raddr[r] = $urandom() & 32'hFFFF_FFFC;
        end
        rdy[r] = 1'($urandom_range(1));
      end
      m_ar  = 1'($urandom_range(1));
      m_dv  = owed && ($urandom_range(1) == 1);
      m_dat = m_dv ? memf(raddr[owner]) : $urandom();
      i0.avalid = pend[0]; i0.addr = raddr[0]; i0.ready = rdy[0];
      d0.avalid = pend[1]; d0.addr = raddr[1]; d0.ready = rdy[1];
      m0.aready = m_ar; m0.dvalid = m_dv; m0.data = m_dat;
      #1;
      chk1("r_mav", m0.avalid, aphase);
      chk32("r_maddr", m0.addr, aphase ? raddr[owner] : '0);
      chk1("r_mrdy", m0.ready, owed ? rdy[owner] : 1'b0);
      chk1("r_iar", i0.aready, aphase && owner == 0 && m_ar);
      chk1("r_dar", d0.aready, aphase && owner == 1 && m_ar);
      chk1("r_idv", i0.dvalid, owed && owner == 0 && m_dv);
      chk1("r_ddv", d0.dvalid, owed && owner == 1 && m_dv);
      chk32("r_idat", i0.data, (owed && owner == 0) ? m_dat : '0);
      chk32("r_ddat", d0.data, (owed && owner == 1) ? m_dat : '0);
      if (aphase) begin
        if (m_ar) begin
          aphase = 1'b0; owed = 1'b1; last = owner;
          pend[owner] = 1'b0; awaitr[owner] = 1'b1;
        end
      end else if (owed) begin
        if (m_dv && rdy[owner]) begin
          chk32("r_rdata", owner == 1 ? d0.data : i0.data,
                memf(raddr[owner]));
          owed = 1'b0; awaitr[owner] = 1'b0; nxfer++;
        end
      end else if (pend[0] || pend[1]) begin
        if (pend[0] && pend[1]) owner = (last == 0) ? 1 : 0;
        else owner = pend[1] ? 1 : 0;
        aphase = 1'b1;
      end
      step();
    end
    chk1("r_progress", nxfer > 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
